// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_fsm
// Purpose  : Moore sequencing controller for the multi-cycle RV64 core.
//            FETCH -> DECODE -> EXEC -> (MEM) -> (WB), with a sticky TRAP
//            state for illegal opcodes and memory handshake timeouts.
// Options  : PERF_COUNTERS_EN adds CycleCount / RetiredCount outputs.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 15,  // 1..255 cycles allowed per memory state
  parameter int CNT_W       = 8    // must be wide enough to hold MEM_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  Opcode,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        IRWrite,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        ALUSrc,
  output logic [1:0]  ALUOp,
  output logic        RegWrite,
  output logic        InstrDone,
  output logic        Fault,
  output logic [2:0]  State
`ifdef PERF_COUNTERS_EN
  ,
  output logic [63:0] CycleCount,
  output logic [63:0] RetiredCount
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  // CLS_NONE doubles as the cleared value and the ILLEGAL class.
  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_R      = 3'd1,
    CLS_I      = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_BRANCH = 3'd5
  } class_t;

  // The wait counter holds the number of cycles already spent waiting, so
  // the current cycle is the last permitted one when it equals TIMEOUT-1.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state;
  state_t           next_state;
  class_t           op_class;
  class_t           dec_class;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_expired;

  // Zero gates the branch PC load in the datapath, not here.
  logic unused_zero;
  assign unused_zero = Zero;

  assign State        = state;
  assign wait_expired = (wait_cnt == WAIT_LAST);

  // Classify the raw opcode; only consumed in DECODE.
  always_comb begin
    dec_class = CLS_NONE;
    case (Opcode)
      7'b0110011: dec_class = CLS_R;
      7'b0010011: dec_class = CLS_I;
      7'b0000011: dec_class = CLS_LOAD;
      7'b0100011: dec_class = CLS_STORE;
      7'b1100011: dec_class = CLS_BRANCH;
      default:    dec_class = CLS_NONE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Latch the instruction class at the DECODE edge.
  always_ff @(posedge clk) begin
    if (reset)                 op_class <= CLS_NONE;
    else if (state == S_DECODE) op_class <= dec_class;
  end

  // Memory wait counter: counts only while staying in FETCH/MEM without
  // MemReady; any other situation (ready, leaving, other states) clears it.
  always_ff @(posedge clk) begin
    if (reset)
      wait_cnt <= '0;
    else if ((state == S_FETCH || state == S_MEM) && !MemReady && next_state == state)
      wait_cnt <= wait_cnt + CNT_W'(1);
    else
      wait_cnt <= '0;
  end

  // Next-state and control outputs; reset forces every control low.
  always_comb begin
    next_state  = state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    Branch      = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrc      = 1'b0;
    ALUOp       = 2'b00;
    RegWrite    = 1'b0;
    InstrDone   = 1'b0;
    Fault       = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          if (MemReady) begin
            IRWrite    = 1'b1;
            PCWrite    = 1'b1;
            next_state = S_DECODE;
          end else if (wait_expired) begin
            next_state = S_TRAP;
          end
        end
        S_DECODE: begin
          next_state = (dec_class == CLS_NONE) ? S_TRAP : S_EXEC;
        end
        S_EXEC: begin
          case (op_class)
            CLS_R: begin
              ALUOp      = 2'b10;
              next_state = S_WB;
            end
            CLS_I: begin
              ALUOp      = 2'b10;
              ALUSrc     = 1'b1;
              next_state = S_WB;
            end
            CLS_LOAD, CLS_STORE: begin
              ALUSrc     = 1'b1;
              next_state = S_MEM;
            end
            CLS_BRANCH: begin
              ALUOp       = 2'b01;
              Branch      = 1'b1;
              PCWriteCond = 1'b1;
              InstrDone   = 1'b1;
              next_state  = S_FETCH;
            end
            default: next_state = S_TRAP;
          endcase
        end
        S_MEM: begin
          IorD = 1'b1;
          if (op_class == CLS_LOAD)       MemRead  = 1'b1;
          else if (op_class == CLS_STORE) MemWrite = 1'b1;
          if (op_class != CLS_LOAD && op_class != CLS_STORE) begin
            next_state = S_TRAP;
          end else if (MemReady) begin
            if (op_class == CLS_LOAD) begin
              next_state = S_WB;
            end else begin
              InstrDone  = 1'b1;
              next_state = S_FETCH;
            end
          end else if (wait_expired) begin
            next_state = S_TRAP;
          end
        end
        S_WB: begin
          RegWrite   = 1'b1;
          InstrDone  = 1'b1;
          MemtoReg   = (op_class == CLS_LOAD);
          next_state = S_FETCH;
        end
        S_TRAP: begin
          Fault = 1'b1;
        end
        default: next_state = S_TRAP;
      endcase
    end
  end

`ifdef PERF_COUNTERS_EN
  // Free-running cycle counter (frozen in TRAP) and retired-instruction count.
  always_ff @(posedge clk) begin
    if (reset) begin
      CycleCount   <= 64'd0;
      RetiredCount <= 64'd0;
    end else begin
      if (state != S_TRAP) CycleCount   <= CycleCount + 64'd1;
      if (InstrDone)       RetiredCount <= RetiredCount + 64'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_fsm
// Purpose  : Self-checking bench for multicycle_control_fsm. Expected
//            behaviour is produced as a per-cycle trace from the instruction
//            class, the fetch wait length and the memory wait length.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;

  localparam int TO = 15;

  // Expected control vector bit masks.
  localparam logic [13:0] K_PCW  = 14'h2000;
  localparam logic [13:0] K_PCWC = 14'h1000;
  localparam logic [13:0] K_IORD = 14'h0800;
  localparam logic [13:0] K_IRW  = 14'h0400;
  localparam logic [13:0] K_BR   = 14'h0200;
  localparam logic [13:0] K_MR   = 14'h0100;
  localparam logic [13:0] K_MW   = 14'h0080;
  localparam logic [13:0] K_M2R  = 14'h0040;
  localparam logic [13:0] K_ASRC = 14'h0020;
  localparam logic [13:0] K_AFN  = 14'h0010;
  localparam logic [13:0] K_ASUB = 14'h0008;
  localparam logic [13:0] K_RW   = 14'h0004;
  localparam logic [13:0] K_DONE = 14'h0002;
  localparam logic [13:0] K_FLT  = 14'h0001;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic       clk, reset, Zero, MemReady;
  logic [6:0] Opcode;
  logic       PCWrite, PCWriteCond, IorD, IRWrite, Branch, MemRead, MemWrite;
  logic       MemtoReg, ALUSrc, RegWrite, InstrDone, Fault;
  logic [1:0] ALUOp;
  logic [2:0] State;
`ifdef PERF_COUNTERS_EN
  logic [63:0] CycleCount, RetiredCount;
`endif

  multicycle_control_fsm #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .IRWrite(IRWrite),
    .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .RegWrite(RegWrite), .InstrDone(InstrDone),
    .Fault(Fault), .State(State)
`ifdef PERF_COUNTERS_EN
    , .CycleCount(CycleCount), .RetiredCount(RetiredCount)
`endif
  );

  logic [13:0] obs_ctl;
  assign obs_ctl = {PCWrite, PCWriteCond, IorD, IRWrite, Branch, MemRead, MemWrite,
                    MemtoReg, ALUSrc, ALUOp, RegWrite, InstrDone, Fault};

  typedef struct {
    logic       rdy;
    logic [6:0] op;
    logic       z;
    logic [2:0] st;
    logic [13:0] ctl;
  } cyc_t;

  cyc_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   fixed_rdy = 0;   // drive MemReady=1 in cycles where it is a don't-care

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic dc_rdy();
    return fixed_rdy ? 1'b1 : 1'($urandom);
  endfunction

  function automatic logic [6:0] rnd_op();
    return 7'($urandom);
  endfunction

  function automatic void push(input logic rdy, input logic [6:0] op, input logic [2:0] st,
                               input logic [13:0] ctl);
    cyc_t r;
    r.rdy = rdy; r.op = op; r.z = 1'($urandom); r.st = st; r.ctl = ctl;
    q.push_back(r);
  endfunction

  function automatic void add_trap(input int n);
    for (int i = 0; i < n; i++) push(dc_rdy(), rnd_op(), 3'd5, K_FLT);
  endfunction

  // Append the expected trace of one instruction. fw / mw are the number of
  // cycles MemReady stays low before it rises in FETCH / MEM; a run of TO
  // low cycles is fatal. Returns 1 if the instruction ends in TRAP.
  function automatic bit add_instr(input logic [6:0] op, input int fw, input int mw,
                                   input int trap_len);
    bit is_ld, is_st;
    logic [13:0] mctl;
    for (int i = 0; i < ((fw >= TO) ? TO : fw); i++) push(1'b0, rnd_op(), 3'd0, K_MR);
    if (fw >= TO) begin add_trap(trap_len); return 1'b1; end
    push(1'b1, rnd_op(), 3'd0, K_MR | K_IRW | K_PCW);
    push(dc_rdy(), op, 3'd1, 14'd0);
    is_ld = (op == OP_LD);
    is_st = (op == OP_ST);
    if (op == OP_R || op == OP_I) begin
      push(dc_rdy(), rnd_op(), 3'd2, K_AFN | ((op == OP_I) ? K_ASRC : 14'd0));
      push(dc_rdy(), rnd_op(), 3'd4, K_RW | K_DONE);
    end else if (op == OP_BR) begin
      push(dc_rdy(), rnd_op(), 3'd2, K_ASUB | K_BR | K_PCWC | K_DONE);
    end else if (is_ld || is_st) begin
      push(dc_rdy(), rnd_op(), 3'd2, K_ASRC);
      mctl = K_IORD | (is_ld ? K_MR : K_MW);
      for (int i = 0; i < ((mw >= TO) ? TO : mw); i++) push(1'b0, rnd_op(), 3'd3, mctl);
      if (mw >= TO) begin add_trap(trap_len); return 1'b1; end
      push(1'b1, rnd_op(), 3'd3, mctl | (is_st ? K_DONE : 14'd0));
      if (is_ld) push(dc_rdy(), rnd_op(), 3'd4, K_RW | K_DONE | K_M2R);
    end else begin
      add_trap(trap_len);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Drive one cycle of stimulus and sample outputs mid-cycle.
  task automatic apply(input cyc_t r, output logic [2:0] s, output logic [13:0] c);
    MemReady = r.rdy; Opcode = r.op; Zero = r.z;
    @(negedge clk);
    s = State; c = obs_ctl;
    @(posedge clk); #1;
  endtask

  task automatic reset_dut(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    cyc_t r; logic [2:0] s; logic [13:0] c; bit t;
    reset = 1'b1; MemReady = 1'b1; Opcode = OP_R; Zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({State, obs_ctl} !== {3'd0, 14'd0}) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d state=%0d ctl=%h exp state=0 ctl=0000", i, State, obs_ctl);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    fixed_rdy = 1;
    t = add_instr(OP_R, 0, 0, 0);
    push(1'b1, rnd_op(), 3'd0, K_MR | K_IRW | K_PCW);
    fixed_rdy = 0;
    while (q.size() > 0) begin
      r = q.pop_front(); apply(r, s, c); checks++;
      if ({s, c} !== {r.st, r.ctl}) begin
        failures++;
        $display("FAIL reset_first_r state=%0d ctl=%h exp state=%0d ctl=%h", s, c, r.st, r.ctl);
      end
    end
  endtask

  task automatic test_load_store_branch();
    cyc_t r; logic [2:0] s; logic [13:0] c; bit t;
    reset_dut(2);
    t = add_instr(OP_LD, 0, 2, 0);   // 7 cycles with MEM lasting 3
    t = add_instr(OP_ST, 1, 0, 0);
    t = add_instr(OP_BR, 0, 0, 0);
    t = add_instr(OP_BR, 0, 0, 0);
    t = add_instr(OP_I, 0, 0, 0);
    t = add_instr(OP_ST, 0, 3, 0);
    while (q.size() > 0) begin
      r = q.pop_front(); apply(r, s, c); checks++;
      if ({s, c} !== {r.st, r.ctl}) begin
        failures++;
        $display("FAIL ld_st_br op=%b state=%0d ctl=%h exp state=%0d ctl=%h", r.op, s, c, r.st, r.ctl);
      end
    end
  endtask

  task automatic test_illegal();
    cyc_t r; logic [2:0] s; logic [13:0] c; bit t;
    reset_dut(1);
    t = add_instr(7'b1111111, 0, 0, 20);
    while (q.size() > 0) begin
      r = q.pop_front(); apply(r, s, c); checks++;
      if ({s, c} !== {r.st, r.ctl}) begin
        failures++;
        $display("FAIL illegal_trap state=%0d ctl=%h exp state=%0d ctl=%h", s, c, r.st, r.ctl);
      end
    end
    reset_dut(1);
    t = add_instr(OP_R, 0, 0, 0);
    while (q.size() > 0) begin
      r = q.pop_front(); apply(r, s, c); checks++;
      if ({s, c} !== {r.st, r.ctl}) begin
        failures++;
        $display("FAIL trap_restart state=%0d ctl=%h exp state=%0d ctl=%h", s, c, r.st, r.ctl);
      end
    end
  endtask

  task automatic test_timeout();
    cyc_t r; logic [2:0] s; logic [13:0] c; bit t;
    // Ready exactly on the TO-th FETCH cycle and TO-th MEM cycle: success.
    reset_dut(1);
    t = add_instr(OP_R, TO - 1, 0, 0);
    t = add_instr(OP_LD, 0, TO - 1, 0);
    t = add_instr(OP_BR, TO, 0, 6);      // never ready in FETCH: trap
    while (q.size() > 0) begin
      r = q.pop_front(); apply(r, s, c); checks++;
      if ({s, c} !== {r.st, r.ctl}) begin
        failures++;
        $display("FAIL fetch_timeout state=%0d ctl=%h exp state=%0d ctl=%h", s, c, r.st, r.ctl);
      end
    end
    reset_dut(1);
    t = add_instr(OP_ST, 0, TO, 5);      // never ready in MEM: trap
    while (q.size() > 0) begin
      r = q.pop_front(); apply(r, s, c); checks++;
      if ({s, c} !== {r.st, r.ctl}) begin
        failures++;
        $display("FAIL mem_timeout state=%0d ctl=%h exp state=%0d ctl=%h", s, c, r.st, r.ctl);
      end
    end
  endtask

  function automatic int pick_wait(input bit allow_trap);
    int k = int'($urandom_range(0, 7));
    if (k <= 3) return k;
    if (k <= 5) return 0;
    if (k == 6) return TO - 1;
    return allow_trap ? TO + int'($urandom_range(0, 2)) : 1;
  endfunction

  task automatic test_back_to_back_random();
    cyc_t r; logic [2:0] s; logic [13:0] c; bit t;
    logic [6:0] ops [5];
    int n;
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LD; ops[3] = OP_ST; ops[4] = OP_BR;
    for (int ep = 0; ep < 8; ep++) begin
      reset_dut(1 + int'($urandom_range(0, 2)));
      n = 3 + int'($urandom_range(0, 5));
      t = 0;
      for (int k = 0; k < n && !t; k++) begin
        bit last = (k == n - 1) && ep[0];
        logic [6:0] op = (last && $urandom_range(0, 2) == 0) ? 7'b0110111
                                                             : ops[$urandom_range(0, 4)];
        t = add_instr(op, pick_wait(last), pick_wait(last), 3);
      end
      while (q.size() > 0) begin
        r = q.pop_front(); apply(r, s, c); checks++;
        if ({s, c} !== {r.st, r.ctl}) begin
          failures++;
          $display("FAIL random ep=%0d op=%b state=%0d ctl=%h exp state=%0d ctl=%h",
                   ep, r.op, s, c, r.st, r.ctl);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; MemReady = 1'b0; Opcode = 7'd0; Zero = 1'b0;
    test_reset();
    test_load_store_branch();
    test_illegal();
    test_timeout();
    test_back_to_back_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequencing controller for the multi-cycle variant of the 64-bit RISC-V core.
- Replaces the purely combinational opcode decode with a Moore FSM: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Drives the shared ALU, the unified instruction/data memory port and the register file.
- Waits on a memory ready handshake and traps on illegal opcodes or memory timeout.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles to wait for MemReady in any memory state before trapping; legal range 1..255.
- CNT_W, 8: width of the internal memory wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Opcode  input  7  instr[6:0] from the instruction register; sampled only in DECODE.
- Zero  input  1  ALU zero flag; sampled in EXEC for branches.
- MemReady  input  1  memory has completed the current read/write this cycle.
- PCWrite  output  1  unconditional PC load (PC+4).
- PCWriteCond  output  1  PC load with branch target when Zero=1.
- IorD  output  1  memory address select: 0 = PC, 1 = ALU result.
- IRWrite  output  1  instruction register load.
- Branch  output  1  branch instruction in EXEC.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- MemtoReg  output  1  writeback source is memory data.
- ALUSrc  output  1  ALU operand B is the immediate.
- ALUOp  output  2  00 add, 01 subtract/compare, 10 funct-decoded.
- RegWrite  output  1  register file write enable.
- InstrDone  output  1  one-cycle pulse on the last cycle of each instruction.
- Fault  output  1  sticky trap indicator.
- State  output  3  current state for debug.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 go to TRAP on the next edge.
- Reset:
  - While reset=1, every output is 0 except State, which shows 0 after the first edge.
  - The state register loads FETCH; the wait counter, opcode class and Fault clear.
  - Reset has priority in every state, including mid-MEM and TRAP.
- Opcode classes, latched at the DECODE edge:
  - R = 0110011
  - I-ALU = 0010011
  - LOAD = 0000011
  - STORE = 0100011
  - BRANCH = 1100011
  - Any other opcode is ILLEGAL.
- FETCH:
  - Outputs: MemRead=1, IorD=0.
  - If MemReady=1: IRWrite=1 and PCWrite=1 in the same cycle, then go to DECODE.
  - Otherwise increment the wait counter.
- DECODE:
  - Outputs all 0.
  - ILLEGAL goes to TRAP; all other classes go to EXEC.
- EXEC:
  - R: ALUOp=10, ALUSrc=0; next state WB.
  - I-ALU: ALUOp=10, ALUSrc=1; next state WB.
  - LOAD/STORE: ALUOp=00, ALUSrc=1; next state MEM.
  - BRANCH: ALUOp=01, ALUSrc=0, Branch=1, PCWriteCond=1, InstrDone=1; next state FETCH. The PC updates only if Zero=1; that gating is done in the datapath.
- MEM:
  - Outputs: IorD=1, and MemRead=1 (LOAD) or MemWrite=1 (STORE).
  - Hold the request until MemReady=1.
  - LOAD then goes to WB; STORE asserts InstrDone=1 and goes to FETCH.
- WB:
  - Outputs: RegWrite=1, InstrDone=1, and MemtoReg=1 for LOAD only.
  - Next state FETCH.
- Wait counter:
  - Clears on entry to FETCH or MEM and whenever MemReady=1.
  - If it reaches MEM_TIMEOUT with MemReady still 0, go to TRAP.
  - MemReady=1 in the same cycle the count reaches MEM_TIMEOUT counts as success; no trap.
- TRAP:
  - Fault=1; all other controls 0.
  - Stays in TRAP until reset.
- Cycle counts with zero-wait memory (MemReady already high on entry):
  - R / I-ALU: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- Invariants:
  - MemRead and MemWrite are never 1 together.
  - RegWrite is never 1 outside WB.

Optional Feature:
- Macro: PERF_COUNTERS_EN.
- When defined:
  - Adds outputs CycleCount[63:0] and RetiredCount[63:0], both cleared by reset.
  - CycleCount increments every non-reset cycle and freezes in TRAP.
  - RetiredCount increments on each InstrDone pulse.
  - Both wrap modulo 2^64.
- When undefined: neither port nor the counter logic exists.

Test Plan:
- Reset held 3 cycles, then released with MemReady=1 and Opcode=0110011 → State sequence 0,1,2,4,0. RegWrite=1 only in WB; one InstrDone pulse; Fault=0.
- LOAD 0000011, MemReady low for 2 cycles in MEM → MEM lasts 3 cycles with MemRead=1 and IorD=1 throughout. Then WB with MemtoReg=1, RegWrite=1; 7 cycles total.
- STORE 0100011 → MEM asserts MemWrite=1 and MemRead=0. InstrDone is asserted in MEM; no WB state and no RegWrite.
- BRANCH 1100011 with Zero=1, then with Zero=0 → EXEC asserts Branch=1, PCWriteCond=1, ALUOp=01; return to FETCH after 3 cycles in both cases.
- Opcode=1111111 → TRAP after DECODE with Fault=1 held for 20 cycles. Reset clears it and the FSM restarts in FETCH.
- MemReady=0 forever in FETCH with MEM_TIMEOUT=15 → TRAP after 15 wait cycles. Repeat with MemReady=1 exactly on the 15th cycle → DECODE, no trap.
